if_id_pipe_reg: RTL and testbench

IF_ID_PIPE_REG -- requirements
Module: if_id_pipe_reg

---
 rtl/if_id_pkg.sv | 13 +
 rtl/if_id_entry.sv | 33 +++
 rtl/if_id_pipe_reg.sv | 127 ++++++++++++
 tb/tb_if_id_pipe_reg.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
// Shared definitions for the IF/ID pipeline register: occupancy state encoding
// and the default bubble instruction.
package if_id_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_entry.sv
// One IF/ID holding entry: next-PC, instruction and valid flag.
// Clear drops only the valid flag, so the PC field keeps its last value.
module if_id_entry #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   clear,
    input  logic [PC_WIDTH-1:0]    load_pc,
    input  logic [INSTR_WIDTH-1:0] load_instr,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   valid
);

    // Entry storage; clear has priority over load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc    <= '0;
            instr <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            pc    <= load_pc;
            instr <= load_instr;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid/ready handshake, flush and a saturating
// stall counter. Define IF_ID_SKID_EN for a two-entry skid buffer with a
// registered readyOUT; otherwise a single entry with combinational readyOUT.
module if_id_pipe_reg
    import if_id_pkg::*;
#(
    parameter int unsigned             PC_WIDTH    = 32,
    parameter int unsigned             INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = INSTR_WIDTH'(NOP_DEFAULT),
    parameter int unsigned             CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PC_WIDTH-1:0]    nextPcIN,
    input  logic [INSTR_WIDTH-1:0] instruccionIN,
    input  logic                   validIN,
    output logic                   readyOUT,
    input  logic                   flushIN,
    output logic [PC_WIDTH-1:0]    nextPcOUT,
    output logic [INSTR_WIDTH-1:0] instruccionOUT,
    output logic                   validOUT,
    input  logic                   readyIN,
    output logic [CNT_WIDTH-1:0]   stallCountOUT
);

    logic                   accept, deliver;
    logic                   main_load, main_clear, main_valid;
    logic [PC_WIDTH-1:0]    main_pc;
    logic [INSTR_WIDTH-1:0] main_instr;
    logic                   skid_valid;
    logic [PC_WIDTH-1:0]    skid_pc;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic [CNT_WIDTH-1:0]   stall_cnt;

    assign accept  = validIN && readyOUT;
    assign deliver = main_valid && readyIN;

    // Output entry loads from the skid slot when it drains, else from IF when
    // it is empty or being delivered this cycle.
    assign main_load  = (accept && (!main_valid || deliver)) || (skid_valid && deliver);
    assign main_clear = flushIN || (deliver && !main_load);

    if_id_entry #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_main (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (main_load),
        .clear      (main_clear),
        .load_pc    (skid_valid ? skid_pc : nextPcIN),
        .load_instr (skid_valid ? skid_instr : instruccionIN),
        .pc         (main_pc),
        .instr      (main_instr),
        .valid      (main_valid)
    );

`ifdef IF_ID_SKID_EN
    state_e state_q, state_d;
    logic   ready_q;

    // Skid slot catches a beat accepted while the output entry is stalled.
    if_id_entry #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (accept && main_valid && !deliver),
        .clear      (flushIN || deliver),
        .load_pc    (nextPcIN),
        .load_instr (instruccionIN),
        .pc         (skid_pc),
        .instr      (skid_instr),
        .valid      (skid_valid)
    );

    // Occupancy next state; flush empties from any state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (accept) state_d = ONE;
            ONE: begin
                if (accept && !deliver)      state_d = TWO;
                else if (!accept && deliver) state_d = EMPTY;
            end
            TWO:     if (deliver) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (flushIN) state_d = EMPTY;
    end

    // Occupancy state and registered ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != TWO);
        end
    end

    // Gate with rst_n so nothing is accepted while reset is asserted.
    assign readyOUT = ready_q && rst_n;
`else
    assign skid_valid = 1'b0;
    assign skid_pc    = '0;
    assign skid_instr = '0;
    assign readyOUT   = rst_n && (!main_valid || readyIN);
`endif

    // Saturating count of cycles the output beat is held by ID.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (main_valid && !readyIN && !flushIN && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign validOUT       = main_valid;
    assign nextPcOUT      = main_pc;
    assign instruccionOUT = main_valid ? main_instr : NOP_INSTR;
    assign stallCountOUT  = stall_cnt;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
module tb_if_id_pipe_reg;

    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef IF_ID_SKID_EN
    localparam int CAP  = 2;
    localparam bit SKID = 1'b1;
`else
    localparam int CAP  = 1;
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, validIN, flushIN, readyIN;
    logic [31:0] nextPcIN, instruccionIN;
    logic        readyOUT, validOUT, readyOUT_s, validOUT_s;
    logic [31:0] nextPcOUT, instruccionOUT, nextPcOUT_s, instruccionOUT_s;
    logic [15:0] stallCountOUT;
    logic [3:0]  stallCountOUT_s;

    always #5 clk = ~clk;

    if_id_pipe_reg u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .nextPcIN       (nextPcIN),
        .instruccionIN  (instruccionIN),
        .validIN        (validIN),
        .readyOUT       (readyOUT),
        .flushIN        (flushIN),
        .nextPcOUT      (nextPcOUT),
        .instruccionOUT (instruccionOUT),
        .validOUT       (validOUT),
        .readyIN        (readyIN),
        .stallCountOUT  (stallCountOUT)
    );

    // Narrow-counter instance for saturation; same inputs, same behaviour.
    if_id_pipe_reg #(.CNT_WIDTH(4)) u_dut_sat (
        .clk            (clk),
        .rst_n          (rst_n),
        .nextPcIN       (nextPcIN),
        .instruccionIN  (instruccionIN),
        .validIN        (validIN),
        .readyOUT       (readyOUT_s),
        .flushIN        (flushIN),
        .nextPcOUT      (nextPcOUT_s),
        .instruccionOUT (instruccionOUT_s),
        .validOUT       (validOUT_s),
        .readyIN        (readyIN),
        .stallCountOUT  (stallCountOUT_s)
    );

    // Reference model: FIFO of beats with capacity CAP.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } beat_t;
    beat_t       mq[$];
    int unsigned m_cnt, m_cnt_sat;
    logic [31:0] m_last_pc;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic m_valid();
        return mq.size() > 0;
    endfunction

    function automatic logic m_ready();
        if (SKID) return rst_n && (mq.size() < CAP);
        return rst_n && (mq.size() == 0 || readyIN);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_cnt = 0;
        m_cnt_sat = 0;
        m_last_pc = '0;
    endtask

    // Apply one clock edge to the model using the current (pre-edge) inputs.
    task automatic model_edge();
        logic acc, del;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = validIN && m_ready();
        del = m_valid() && readyIN;
        if (m_valid() && !readyIN && !flushIN) begin
            if (m_cnt < 32'hFFFF) m_cnt++;
            if (m_cnt_sat < 15) m_cnt_sat++;
        end
        if (flushIN) begin
            mq.delete();
        end else begin
            if (del) void'(mq.pop_front());
            if (acc) mq.push_back('{pc: nextPcIN, instr: instruccionIN});
        end
        if (mq.size() > 0) m_last_pc = mq[0].pc;
    endtask

    task automatic compare_all();
        logic [31:0] exp_instr;
        exp_instr = m_valid() ? mq[0].instr : NOP;
        check("valid",     validOUT, m_valid());
        check("instr",     instruccionOUT, exp_instr);
        check("pc",        nextPcOUT, m_last_pc);
        check("ready",     readyOUT, m_ready());
        check("stall_cnt", stallCountOUT, m_cnt);
        check("sat_cnt",   stallCountOUT_s, m_cnt_sat);
        check("sat_valid", validOUT_s, m_valid());
        check("sat_ready", readyOUT_s, m_ready());
    endtask

    // Drive one cycle: inputs, mid-cycle compare, then step the model at the edge.
    task automatic cycle(input logic rst, input logic vin, input logic [31:0] pc,
                         input logic [31:0] ins, input logic fl, input logic rin);
        rst_n = rst; validIN = vin; nextPcIN = pc; instruccionIN = ins;
        flushIN = fl; readyIN = rin;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; validIN = 1'b1; flushIN = 1'b0; readyIN = 1'b1;
        nextPcIN = '0; instruccionIN = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset held two cycles with validIN high.
        cycle(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b1);
        check("rst_valid", validOUT, 1'b0);
        check("rst_instr", instruccionOUT, 32'h0000_0000);
        check("rst_cnt",   stallCountOUT, 16'd0);

        // Streaming.
        cycle(1'b1, 1'b1, 32'h4, 32'h1111_0000, 1'b0, 1'b1);
        check("str_b0", instruccionOUT, 32'h1111_0000);
        cycle(1'b1, 1'b1, 32'h8, 32'hFFFF_0000, 1'b0, 1'b1);
        check("str_b1", instruccionOUT, 32'hFFFF_0000);
        cycle(1'b1, 1'b1, 32'hC, 32'h0000_FFFF, 1'b0, 1'b1);
        check("str_b2", instruccionOUT, 32'h0000_FFFF);
        check("str_pc2", nextPcOUT, 32'hC);
        cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Stall five cycles with a beat held.
        cycle(1'b1, 1'b1, 32'h10, 32'h1111_0000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 32'h14, 32'h2222_0000, 1'b0, 1'b0);
        check("stall_cnt5",   stallCountOUT, 16'd5);
        check("stall_instr",  instruccionOUT, 32'h1111_0000);
        check("stall_pc",     nextPcOUT, 32'h10);
        check("stall_ready",  readyOUT, 1'b0);

        // Flush with a held beat and an offered beat.
        cycle(1'b1, 1'b1, 32'h18, 32'h3030_0000, 1'b1, 1'b0);
        check("flush_valid", validOUT, 1'b0);
        check("flush_instr", instruccionOUT, NOP);
        cycle(1'b1, 1'b1, 32'h1C, 32'h3333_0000, 1'b0, 1'b0);
        check("post_flush_valid", validOUT, 1'b1);
        check("post_flush_instr", instruccionOUT, 32'h3333_0000);

        // 20-cycle stall saturates the 4-bit counter.
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 32'h20, 32'h4444_0000, 1'b0, 1'b0);
        check("sat_cnt_f", stallCountOUT_s, 4'hF);
        check("wide_cnt",  stallCountOUT, 16'd25);

        // Reset in the middle of a stall.
        cycle(1'b0, 1'b1, 32'h24, 32'h5555_0000, 1'b1, 1'b0);
        check("mid_rst_valid", validOUT, 1'b0);
        check("mid_rst_pc",    nextPcOUT, 32'h0);
        check("mid_rst_cnt",   stallCountOUT, 16'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(63) != 0), $urandom_range(1), $urandom, $urandom,
                  ($urandom_range(15) == 0), ($urandom_range(9) < 7));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
